ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch unit between next_address_logic and instruction memory.
- Accepts the PC address from next_address_logic and runs a req/ack read to instruction memory. Buffers the returned word and hands it to the decoder with a valid/ready handshake.
- Back-pressures the PC through pc_stall and discards in-flight fetches when a branch or jump is taken (flush).

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_addr  in  ADDR_W  address from next_address_logic.
- pc_valid  in  1  pc_addr is valid this cycle.
- pc_stall  out  1  PC must hold; pc_addr is not accepted this cycle.
- flush  in  1  branch/jump taken; discard any outstanding fetch or buffered instruction.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data, sampled on the mem_ack cycle.
- mem_ack  in  1  memory read done.
- instr  out  DATA_W  fetched instruction to the decoder.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decoder accepts instr.
- fault  out  1  one-cycle pulse: misaligned pc_addr rejected.
- fetch_count  out  CNT_W  count of instructions accepted by the decoder.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_valid=0, fault=0, fetch_count=0. pc_stall=0.
- States: IDLE, REQ, HOLD, DROP. The state is registered; outputs are registered except pc_stall.
- pc_stall is combinational:
  - 1 in REQ and DROP.
  - 1 in HOLD unless (instr_ready=1 or flush=1).
  - 0 in IDLE.
- Address accept: an "accept" occurs when pc_valid=1 and pc_stall=0.
  - Aligned address (pc_addr[1:0]=00): mem_addr<=pc_addr, mem_req<=1, next state REQ.
  - Misaligned address: fault<=1 for one cycle, no request, next state IDLE.
- IDLE:
  - flush has no effect.
  - Accept rules apply.
- REQ:
  - mem_req and mem_addr are held stable until mem_ack. A request is never withdrawn.
  - mem_ack=1, flush=0: instr<=mem_rdata, instr_valid<=1, mem_req<=0, go to HOLD.
  - mem_ack=1, flush=1: discard data, mem_req<=0, go to IDLE.
  - mem_ack=0, flush=1: go to DROP; mem_req stays 1.
- DROP:
  - mem_req is held until mem_ack.
  - On mem_ack: discard data, mem_req<=0, go to IDLE.
  - pc_valid is ignored in DROP. next_address_logic holds the target because pc_stall=1.
- HOLD:
  - instr_valid=1 and instr is held stable.
  - instr_ready=1, flush=0: fetch_count<=fetch_count+1 (wraps at 2^CNT_W). instr_valid<=0. If an accept occurs in the same cycle, issue REQ back-to-back (zero bubble); otherwise go to IDLE.
  - flush=1: instr_valid<=0 and no count, regardless of instr_ready. An accept in the same cycle goes to REQ; otherwise go to IDLE.
- Priority: flush over mem_ack/instr_ready; accept is evaluated after flush.
- Latency: accept to mem_req=1 is 1 cycle. mem_ack to instr_valid=1 is 1 cycle.
- Reset mid-operation: immediate return to reset values. A pending memory transaction is abandoned; memory must tolerate req dropping on reset.

Test Plan:
- Reset, then pc_addr=0x0000_0000, pc_valid=1; mem_ack after 2 cycles with mem_rdata=0x2008_0005; instr_ready=1 -> mem_req high 1 cycle after accept, mem_addr=0; instr=0x2008_0005, instr_valid for 1 cycle; fetch_count=1.
- Sequential fetch 0x0, 0x4, 0x8 with mem_ack every cycle and instr_ready held 1 -> back-to-back REQs, no idle bubble; fetch_count=3; pc_stall low on each HOLD/ready cycle.
- In HOLD with instr_ready=0 for 3 cycles -> instr stable, pc_stall=1, instr_valid=1; then ready=1 -> accepted once, count+1.
- Flush in REQ before ack, pc_valid=1 with pc_addr=0x0000_1000 -> DROP, mem_req held; after ack, data not presented; then fetch 0x1000 issued; no instr_valid for the dropped word.
- Flush in the same cycle as mem_ack -> data discarded, IDLE next cycle, instr_valid stays 0; flush in HOLD with instr_ready=1 -> no count increment.
- pc_addr=0x0000_0006, pc_valid=1 -> fault pulses 1 cycle, mem_req stays 0; assert rst=0 mid-REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: takes a PC from next_address_logic, runs one
// req/ack read to instruction memory, buffers the word and offers it to the
// decoder with a valid/ready handshake. A flush discards any outstanding
// fetch or buffered instruction.
module ifetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  output logic              pc_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                mem_req_next;
  logic [ADDR_W-1:0]   mem_addr_next;
  logic [DATA_W-1:0]   instr_next;
  logic                instr_valid_next;
  logic                fault_next;
  logic [CNT_W-1:0]    fetch_count_next;

  logic                accept;
  logic                aligned;

  // PC back-pressure: only IDLE, or HOLD being released this cycle, can take
  // a new address.
  always_comb begin
    pc_stall = 1'b0;
    case (state_reg)
      IDLE:    pc_stall = 1'b0;
      REQ:     pc_stall = 1'b1;
      DROP:    pc_stall = 1'b1;
      HOLD:    pc_stall = ~(instr_ready | flush);
      default: pc_stall = 1'b0;
    endcase
  end

  assign accept  = pc_valid & ~pc_stall;
  assign aligned = (pc_addr[1:0] == 2'b00);

  // Next-state and registered-output logic; flush outranks ack/ready, and a
  // new address is considered only once flush has been handled.
  always_comb begin
    state_next       = state_reg;
    mem_req_next     = mem_req;
    mem_addr_next    = mem_addr;
    instr_next       = instr;
    instr_valid_next = instr_valid;
    fault_next       = 1'b0;
    fetch_count_next = fetch_count;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (aligned) begin
            mem_addr_next = pc_addr;
            mem_req_next  = 1'b1;
            state_next    = REQ;
          end else begin
            fault_next = 1'b1;
            state_next = IDLE;
          end
        end
      end

      REQ: begin
        if (flush) begin
          if (mem_ack) begin
            mem_req_next = 1'b0;
            state_next   = IDLE;
          end else begin
            state_next = DROP;
          end
        end else if (mem_ack) begin
          instr_next       = mem_rdata;
          instr_valid_next = 1'b1;
          mem_req_next     = 1'b0;
          state_next       = HOLD;
        end
      end

      DROP: begin
        // Wait out the abandoned read; its data is never presented.
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end
      end

      HOLD: begin
        if (flush) begin
          instr_valid_next = 1'b0;
        end else if (instr_ready) begin
          instr_valid_next = 1'b0;
          fetch_count_next = fetch_count + 1'b1;
        end
        if (flush || instr_ready) begin
          state_next = IDLE;
          if (accept) begin
            if (aligned) begin
              // Back-to-back request: no idle bubble after delivery.
              mem_addr_next = pc_addr;
              mem_req_next  = 1'b1;
              state_next    = REQ;
            end else begin
              fault_next = 1'b1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req     <= mem_req_next;
      mem_addr    <= mem_addr_next;
      instr       <= instr_next;
      instr_valid <= instr_valid_next;
      fault       <= fault_next;
      fetch_count <= fetch_count_next;
    end
  end

endmodule
